// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the iterative execute-stage ALU:
//   alu_op_e      4-bit operation codes produced by the ALU controller
//   shift_kind_e  direction/fill mode of the serial shifter
//   state_e       iter_alu control states
//   is_shift()    true for the three shift operations
//   shift_kind()  maps a shift operation onto its shifter mode
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_XOR = 4'b0010,
      OP_ADD = 4'b0011,
      OP_BNE = 4'b0100,
      OP_BLT = 4'b0101,
      OP_BGE = 4'b0110,
      OP_SLT = 4'b0111,
      OP_BEQ = 4'b1000,
      OP_SUB = 4'b1001,
      OP_SRA = 4'b1010,
      OP_SRL = 4'b1011,
      OP_SLL = 4'b1100
   } alu_op_e;

   typedef enum logic [1:0] {
      SK_SLL = 2'd0,
      SK_SRL = 2'd1,
      SK_SRA = 2'd2
   } shift_kind_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   function automatic shift_kind_e shift_kind(input logic [3:0] op);
      case (op)
         OP_SRL:  return SK_SRL;
         OP_SRA:  return SK_SRA;
         default: return SK_SLL;
      endcase
   endfunction

endpackage

// File: rtl/iter_alu_serial_shifter.sv
// -----------------------------------------------------------------------------
// serial_shifter
// One-bit-per-cycle shift register with a down-counter for the shift amount.
//   clk, reset   clock, asynchronous active-high reset
//   clear        abandon the current shift (count returns to 0)
//   load         capture load_data, load_count and kind
//   enable       perform one 1-bit shift and decrement the count
//   kind         shift mode (shift_kind_e encoding)
//   load_data    value to be shifted
//   load_count   shift amount, must be non-zero when loaded
//   next_data    register contents after the shift performed this cycle
//   last         the shift performed this cycle is the final one
// -----------------------------------------------------------------------------
module serial_shifter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   load,
   input  logic                   enable,
   input  logic [1:0]             kind,
   input  logic [DATA_WIDTH-1:0]  load_data,
   input  logic [SHAMT_WIDTH-1:0] load_count,
   output logic [DATA_WIDTH-1:0]  next_data,
   output logic                   last
);

   logic [DATA_WIDTH-1:0]  data;
   logic [SHAMT_WIDTH-1:0] count;
   shift_kind_e            kind_q;

   // NOTE: every variable assigned in always_comb gets a value on every path
   // (default first), otherwise synthesis infers a latch.
   always_comb begin
      next_data = data;
      case (kind_q)
         SK_SLL:  next_data = {data[DATA_WIDTH-2:0], 1'b0};
         SK_SRL:  next_data = {1'b0, data[DATA_WIDTH-1:1]};
         SK_SRA:  next_data = {data[DATA_WIDTH-1], data[DATA_WIDTH-1:1]};
         default: next_data = data;
      endcase
   end

   // Count is never 0 while a shift is active, so count==1 marks the final step.
   assign last = (count == SHAMT_WIDTH'(1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data   <= '0;
         count  <= '0;
         kind_q <= SK_SLL;
      end else if (clear) begin
         count  <= '0;
      end else if (load) begin
         data   <= load_data;
         count  <= load_count;
         kind_q <= shift_kind_e'(kind);
      end else if (enable) begin
         data   <= next_data;
         count  <= count - SHAMT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/iter_alu.sv
// -----------------------------------------------------------------------------
// iter_alu
// Multi-cycle execute-stage ALU. Logic, arithmetic, compare and branch-condition
// ops finish in one registered cycle; shifts go through a serial 1-bit shifter.
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      synchronous abort of the current or pending op
//   in_valid   operation/src_a/src_b are valid
//   in_ready   block can accept an op this cycle
//   operation  4-bit ALU operation code (alu_op_e)
//   src_a      operand A
//   src_b      operand B; low SHAMT_WIDTH bits are the shift amount
//   out_valid  one-cycle pulse, result/zero are valid
//   result     registered result, held until the next completion
//   zero       registered, 1 when result == 0
// -----------------------------------------------------------------------------
module iter_alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            operation,
   input  logic [DATA_WIDTH-1:0] src_a,
   input  logic [DATA_WIDTH-1:0] src_b,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  zero
);

   state_e                 state;
   alu_op_e                op;
   logic [DATA_WIDTH-1:0]  alu_out;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic                   accept;
   logic                   start_shift;
   logic                   sh_last;
   logic [DATA_WIDTH-1:0]  sh_next;
   logic [1:0]             sh_kind;

   assign op          = alu_op_e'(operation);
   assign shamt       = src_b[SHAMT_WIDTH-1:0];
   assign in_ready    = (state == ST_IDLE) && !flush;
   assign accept      = in_valid && in_ready;
   assign start_shift = accept && is_shift(operation) && (shamt != '0);
   assign sh_kind     = shift_kind(operation);

   // Single-cycle datapath. Shift codes only reach this path with a zero
   // shift amount, where the result is src_a unchanged.
   always_comb begin
      alu_out = '0;
      case (op)
         OP_AND: alu_out = src_a & src_b;
         OP_OR:  alu_out = src_a | src_b;
         OP_XOR: alu_out = src_a ^ src_b;
         OP_ADD: alu_out = src_a + src_b;
         OP_SUB: alu_out = src_a - src_b;
         OP_SLT,
         OP_BLT: alu_out[0] = $signed(src_a) < $signed(src_b);
         OP_BGE: alu_out[0] = $signed(src_a) >= $signed(src_b);
         OP_BEQ: alu_out[0] = src_a == src_b;
         OP_BNE: alu_out[0] = src_a != src_b;
         OP_SLL,
         OP_SRL,
         OP_SRA: alu_out = src_a;
         default: alu_out = '0;
      endcase
   end

   serial_shifter #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SHAMT_WIDTH (SHAMT_WIDTH)
   ) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .clear      (flush),
      .load       (start_shift),
      .enable     ((state == ST_SHIFT) && !flush),
      .kind       (sh_kind),
      .load_data  (src_a),
      .load_count (shamt),
      .next_data  (sh_next),
      .last       (sh_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
      end else begin
         out_valid <= 1'b0;
         // In IDLE flush only blocks the accept (through in_ready).
         if (flush && (state != ST_IDLE)) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_shift) begin
                     state <= ST_SHIFT;
                  end else if (accept) begin
                     result    <= alu_out;
                     zero      <= (alu_out == '0);
                     out_valid <= 1'b1;
                     state     <= ST_DONE;
                  end
               end
               ST_SHIFT: begin
                  if (sh_last) begin
                     result    <= sh_next;
                     zero      <= (sh_next == '0);
                     out_valid <= 1'b1;
                     state     <= ST_DONE;
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iter_alu.sv
// -----------------------------------------------------------------------------
// tb_iter_alu
// Directed, table-driven bench for iter_alu (DATA_WIDTH = 32). Inputs change
// and outputs are sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_iter_alu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  operation;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        out_valid;
   logic [31:0] result;
   logic        zero;

   int checks_total  = 0;
   int checks_passed = 0;

   logic [31:0] last_res;
   logic        last_z;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      int          lat;   // cycles from accept edge to the out_valid cycle
   } vec_t;

   vec_t vecs[$];

   iter_alu #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operation (operation),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .result    (result),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act !== exp)
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      else
         checks_passed++;
   endtask

   task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic z, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res; v.z = z; v.lat = lat;
      vecs.push_back(v);
   endtask

   // Issue one op starting at a falling edge, wait for its completion and
   // check latency, result, zero, the in_ready profile and the pulse width.
   // Returns at a falling edge with the DUT idle.
   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z,
                         input int exp_lat);
      int   lat;
      logic ready_ok;
      operation = op; src_a = a; src_b = b; in_valid = 1'b1;
      #1;
      check({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      // Scramble inputs after accept: the op must already be captured.
      in_valid  = 1'b0;
      operation = 4'($urandom);
      src_a     = $urandom;
      src_b     = $urandom;
      @(negedge clk);
      lat      = 1;
      ready_ok = 1'b1;
      while (!out_valid && lat < 40) begin
         if (in_ready) ready_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " result"}, result, exp_r);
      check({name, " zero"}, {31'b0, zero}, {31'b0, exp_z});
      check({name, " ready_low_while_busy"}, {31'b0, ready_ok && !in_ready}, 32'd1);
      @(negedge clk);
      check({name, " pulse_end"}, {30'b0, out_valid, in_ready}, 32'b01);
      check({name, " result_held"}, result, exp_r);
      last_res = exp_r;
      last_z   = exp_z;
   endtask

   initial begin
      int   seen;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
      operation = 4'b0; src_a = '0; src_b = '0;
      last_res = '0; last_z = 1'b1;

      // Directed vectors: op, a, b, expected result, expected zero, latency.
      add_vec(OP_ADD, 32'd5,        32'd7,        32'd12,       1'b0, 1);
      add_vec(OP_SUB, 32'h1234,     32'h1234,     32'h0,        1'b1, 1);
      add_vec(OP_BLT, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1);
      add_vec(OP_BGE, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1);
      add_vec(OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1);
      add_vec(OP_OR,  32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1);
      add_vec(OP_XOR, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1);
      add_vec(OP_ADD, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b1, 1);
      add_vec(OP_SUB, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1);
      add_vec(OP_SLT, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0, 1);
      add_vec(OP_SLT, 32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b1, 1);
      add_vec(OP_BEQ, 32'd3,        32'd3,        32'd1,        1'b0, 1);
      add_vec(OP_BNE, 32'd3,        32'd3,        32'd0,        1'b1, 1);
      add_vec(OP_BNE, 32'd3,        32'd4,        32'd1,        1'b0, 1);
      add_vec(OP_BGE, 32'd5,        32'd5,        32'd1,        1'b0, 1);
      add_vec(OP_BLT, 32'd5,        32'd5,        32'd0,        1'b1, 1);
      add_vec(OP_ADD, 32'd9,        32'd9,        32'd18,       1'b0, 1);
      add_vec(4'b1111, 32'd5,       32'd7,        32'd0,        1'b1, 1);
      add_vec(4'b1101, 32'hFFFF,    32'h1,        32'd0,        1'b1, 1);
      add_vec(OP_SLL, 32'd1,        32'd4,        32'h10,       1'b0, 5);
      add_vec(OP_SRA, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 32);
      add_vec(OP_SRL, 32'hF0,       32'h20,       32'hF0,       1'b0, 1);
      add_vec(OP_SRL, 32'h80000000, 32'd31,       32'd1,        1'b0, 32);
      add_vec(OP_SRA, 32'h7FFFFFF0, 32'd4,        32'h07FFFFFF, 1'b0, 5);
      add_vec(OP_SLL, 32'h80000001, 32'd1,        32'h2,        1'b0, 2);
      add_vec(OP_SRA, 32'h80000000, 32'hFFFFFFE1, 32'hC0000000, 1'b0, 2);
      add_vec(OP_SLL, 32'h80000000, 32'd1,        32'h0,        1'b1, 2);

      // Reset state.
      #2;
      check("reset in_ready",  {31'b0, in_ready},  32'd1);
      check("reset out_valid", {31'b0, out_valid}, 32'd0);
      check("reset result",    result,             32'd0);
      check("reset zero",      {31'b0, zero},      32'd1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].z, vecs[i].lat);

      // Flush during the third SHIFT cycle of an SLL by 10.
      run_op("pre_flush", OP_ADD, 32'd100, 32'd23, 32'd123, 1'b0, 1);
      operation = OP_SLL; src_a = 32'd3; src_b = 32'd10; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_shift in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_shift in_ready_after", {31'b0, in_ready},  32'd1);
      check("flush_shift out_valid",      {31'b0, out_valid}, 32'd0);
      check("flush_shift result",         result,             last_res);
      check("flush_shift zero",           {31'b0, zero},      {31'b0, last_z});
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("flush_shift no_out_valid", 32'(seen), 32'd0);

      // Flush together with in_valid in IDLE blocks the accept.
      operation = OP_ADD; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
      #1;
      check("flush_idle in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      seen = 0;
      repeat (4) begin
         #1;
         if (out_valid) seen++;
         @(negedge clk);
      end
      check("flush_idle no_out_valid", 32'(seen), 32'd0);
      check("flush_idle result", result, last_res);

      // Asynchronous reset in the middle of a shift.
      operation = OP_SLL; src_a = 32'd1; src_b = 32'd20; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_reset in_ready",  {31'b0, in_ready},  32'd1);
      check("mid_reset out_valid", {31'b0, out_valid}, 32'd0);
      check("mid_reset result",    result,             32'd0);
      check("mid_reset zero",      {31'b0, zero},      32'd1);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("mid_reset op_dropped", 32'(seen), 32'd0);
      run_op("post_reset_add", OP_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Multi-cycle execute-stage ALU. It sits directly downstream of the ALU controller and consumes that block's 4-bit Operation code together with two register/immediate operands.
- Add, sub, logic, compare and branch-condition ops complete in one registered cycle.
- Shifts run on a serial 1-bit-per-cycle shifter, so area stays small.
- A valid/ready handshake lets the pipeline stall while a shift is in progress.

Parameters:
- DATA_WIDTH, 32, operand and result width. Must be a power of 2, at least 8.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), width of the shift amount taken from src_b.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous abort of the current or pending op (branch mispredict)
- in_valid  input  1  operation/src_a/src_b are valid
- in_ready  output  1  block can accept an op this cycle
- operation  input  4  ALU operation code from the ALU controller
- src_a  input  DATA_WIDTH  operand A
- src_b  input  DATA_WIDTH  operand B; for shifts, bits [SHAMT_WIDTH-1:0] give the amount
- out_valid  output  1  result/zero are valid; 1-cycle pulse
- result  output  DATA_WIDTH  registered result, held until the next completion
- zero  output  1  registered; 1 when result == 0

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, shift count=0.
- Operation encoding (fixed; lives in the package):
  - AND=0000, OR=0001, XOR=0010, ADD=0011, SUB=1001, SLT=0111
  - SLL=1100, SRL=1011, SRA=1010
  - BEQ=1000, BNE=0100, BLT=0101, BGE=0110
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^DATA_WIDTH.
  - SLT, BLT and BGE compare signed. SLT yields {0..,a<b}.
  - Branch ops yield {0..,cond}: BEQ a==b, BNE a!=b, BLT a<b, BGE a>=b.
  - Any unlisted code yields result 0 on the single-cycle path; it is not an error.
- State machine, IDLE / SHIFT / DONE:
  - in_ready = (state==IDLE) && !flush.
  - Accept happens when in_valid && in_ready at a rising edge.
  - IDLE, accepting a non-shift op: register result and zero, go to DONE.
  - IDLE, accepting a shift with shamt==0: result=src_a, go to DONE.
  - IDLE, accepting a shift with shamt=k>0: load the shift register with src_a, count=k, latch the shift kind, go to SHIFT.
  - SHIFT, each cycle: shift 1 bit (SLL inserts 0 at LSB; SRL inserts 0 at MSB; SRA replicates the MSB), then count--. When count goes 1→0, load result and zero and go to DONE.
  - DONE: out_valid=1 for exactly this cycle, then IDLE. No accept is possible in DONE, so back-to-back ops issue every 2 cycles.
- Latency, with accept at edge of cycle N:
  - Non-shift op: out_valid in cycle N+1.
  - Shift by k: out_valid in cycle N+1+k. in_ready is low for k+1 cycles.
- Flush (synchronous):
  - In IDLE, flush blocks the accept; flush wins over a simultaneous in_valid.
  - In SHIFT or DONE, flush returns to IDLE next edge with out_valid=0. result and zero keep their last committed values.
- Reset mid-operation: asynchronously returns every output to its reset value immediately; the in-flight op is dropped.
- Operand capture: operands are captured at accept; input changes after accept have no effect.

Decomposition:
- alu_pkg holds:
  - the alu_op_e enum (4-bit) with the encodings above
  - a helper function is_shift(op)
  - the shift-kind enum {SK_SLL, SK_SRL, SK_SRA}
- Sub-module serial_shifter: load, enable, kind, DATA_WIDTH shift register, and the down-counter with a done flag. The FSM and the single-cycle datapath stay in iter_alu.

Test Plan:
- ADD src_a=5, src_b=7, accept at cycle N → out_valid at N+1, result=12, zero=0, in_ready high again at N+2.
- SUB 0x1234 − 0x1234 → result=0, zero=1. BLT with a=0xFFFFFFFF, b=1 → result=1. BGE with the same operands → result=0.
- SLL a=1, b=4 → in_ready low for cycles N+1..N+5, out_valid at N+5, result=0x10. Then SRA a=0x80000000, b=31 → out_valid 32 cycles after accept, result=0xFFFFFFFF.
- SRL a=0xF0, b=0x20 (shamt=0) → out_valid at N+1, result=0xF0. SRL a=0x80000000, b=31 → result=1.
- Flush during cycle 3 of an SLL by 10 → no out_valid, result unchanged, in_ready=1 next cycle. flush=1 with in_valid=1 in IDLE → no accept.
- Assert reset during SHIFT → outputs immediately return to reset values (in_ready=1, out_valid=0, result=0, zero=1). A following ADD 2+2 produces 4 normally.
